// File: rtl/systolic_ctrl_pkg.sv
// Shared types for the systolic array sequencer: FSM states, latched command and mode encoding.
package systolic_ctrl_pkg;

   localparam int SEQ_K_W    = 8;
   localparam int SEQ_ADDR_W = 10;

   localparam logic MODE_OS = 1'b1;
   localparam logic MODE_WS = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      DRAIN,
      DONE
   } seq_state_e;

   typedef struct packed {
      logic                  mode;
      logic [SEQ_K_W-1:0]    k;
      logic [SEQ_ADDR_W-1:0] a_base;
      logic [SEQ_ADDR_W-1:0] b_base;
   } seq_cmd_t;

endpackage

// File: rtl/systolic_addr_gen.sv
// Operand buffer address generator: loads a base, then steps up or down per read, wrapping mod 2^ADDR_W.
module systolic_addr_gen #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic              step,
   input  logic              down,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] addr_next;

   // The base is bypassed onto addr in the load cycle so the first read needs no setup cycle.
   always_comb begin
      addr      = load ? base : addr_reg;
      addr_next = addr;
      if (step) begin
         addr_next = down ? (addr - ADDR_W'(1)) : (addr + ADDR_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg <= '0;
      end else begin
         addr_reg <= addr_next;
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// GEMM-tile sequencer for an NxN systolic MAC array (WS and OS runs).
// Optional SYSTOLIC_SEQ_PERF_EN adds the saturating busy-cycle counter perf_cycles.
module systolic_seq_ctrl
   import systolic_ctrl_pkg::*;
#(
   parameter int N      = 4,
   parameter int K_W    = SEQ_K_W,
   parameter int ADDR_W = SEQ_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_mode,
   input  logic [K_W-1:0]    cmd_k,
   input  logic [ADDR_W-1:0] cmd_a_base,
   input  logic [ADDR_W-1:0] cmd_b_base,
   output logic              a_rd_en,
   output logic [ADDR_W-1:0] a_rd_addr,
   output logic              b_rd_en,
   output logic [ADDR_W-1:0] b_rd_addr,
   output logic              arr_mode,
   output logic              arr_state,
   output logic              sum_zero,
   output logic              res_valid,
   output logic [K_W-1:0]    res_idx,
   output logic              busy,
   output logic              done
`ifdef SYSTOLIC_SEQ_PERF_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   // Wide enough for K plus the OS skew tail (K+2N-2) without wrapping.
   localparam int CNT_W = K_W + 1 + $clog2(N);

   seq_state_e       state_reg, state_next;
   seq_cmd_t         cmd_reg;
   logic [CNT_W-1:0] cnt_reg, cnt_next, last_cnt, k_ext;
   logic             accept;
   logic             arr_state_next, sum_zero_next;
   logic [2*N:0]     ws_pipe_reg;
   logic             os_res_reg;
   logic [K_W-1:0]   idx_reg;

   logic              ag_load;
   logic [ADDR_W-1:0] ag_base [2];
   logic [ADDR_W-1:0] ag_addr [2];
   logic              ag_step [2];
   logic              ag_down [2];

   assign k_ext = CNT_W'(cmd_reg.k);

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg + CNT_W'(1);
      last_cnt       = '0;
      accept         = 1'b0;
      cmd_ready      = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      a_rd_en        = 1'b0;
      b_rd_en        = 1'b0;
      arr_state_next = 1'b0;
      sum_zero_next  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            cmd_ready = 1'b1;
            cnt_next  = '0;
            if (cmd_valid) begin
               accept     = 1'b1;
               state_next = (cmd_k == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            busy = 1'b1;
            if (cmd_reg.mode == MODE_WS) begin
               b_rd_en  = 1'b1;
               last_cnt = CNT_W'(N - 1);
            end else begin
               sum_zero_next = 1'b1;
            end
            if (cnt_reg == last_cnt) begin
               state_next = COMPUTE;
               cnt_next   = '0;
            end
         end
         COMPUTE: begin
            busy           = 1'b1;
            arr_state_next = 1'b1;
            if (cmd_reg.mode == MODE_WS) begin
               a_rd_en       = 1'b1;
               sum_zero_next = 1'b1;
               last_cnt      = k_ext - CNT_W'(1);
            end else begin
               a_rd_en  = (cnt_reg < k_ext);
               b_rd_en  = (cnt_reg < k_ext);
               last_cnt = k_ext + CNT_W'(2 * N - 3);
            end
            if (cnt_reg == last_cnt) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end
         end
         DRAIN: begin
            busy          = 1'b1;
            sum_zero_next = 1'b1;
            if (cmd_reg.mode == MODE_WS) begin
               arr_state_next = 1'b1;
               last_cnt       = CNT_W'(2 * N - 2);
            end else begin
               last_cnt = CNT_W'(N - 1);
            end
            if (cnt_reg == last_cnt) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Both generators take their base in the first LOAD cycle; WS weights are fetched last row first.
   assign ag_load    = (state_reg == LOAD) && (cnt_reg == '0);
   assign ag_base[0] = ADDR_W'(cmd_reg.a_base);
   assign ag_base[1] = (cmd_reg.mode == MODE_WS) ? (ADDR_W'(cmd_reg.b_base) + ADDR_W'(N - 1))
                                                 : ADDR_W'(cmd_reg.b_base);
   assign ag_step[0] = a_rd_en;
   assign ag_step[1] = b_rd_en;
   assign ag_down[0] = 1'b0;
   assign ag_down[1] = (cmd_reg.mode == MODE_WS);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_addr
         systolic_addr_gen #(
            .ADDR_W (ADDR_W)
         ) u_addr_gen (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (ag_load),
            .base  (ag_base[gi]),
            .step  (ag_step[gi]),
            .down  (ag_down[gi]),
            .addr  (ag_addr[gi])
         );
      end
   endgenerate

   assign a_rd_addr = ag_addr[0];
   assign b_rd_addr = ag_addr[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         cmd_reg     <= '0;
         arr_state   <= 1'b0;
         sum_zero    <= 1'b0;
         arr_mode    <= 1'b0;
         ws_pipe_reg <= '0;
         os_res_reg  <= 1'b0;
         idx_reg     <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            cmd_reg <= '{mode:   cmd_mode,
                         k:      SEQ_K_W'(cmd_k),
                         a_base: SEQ_ADDR_W'(cmd_a_base),
                         b_base: SEQ_ADDR_W'(cmd_b_base)};
         end
         arr_state <= arr_state_next;
         sum_zero  <= sum_zero_next;
         arr_mode  <= busy & cmd_reg.mode;
         // WS results emerge from the bottom row 2N+1 cycles after the A vector was read.
         ws_pipe_reg <= {ws_pipe_reg[2*N-1:0], a_rd_en & (cmd_reg.mode == MODE_WS)};
         os_res_reg  <= (state_reg == DRAIN) && (cmd_reg.mode == MODE_OS);
         if (accept) begin
            idx_reg <= '0;
         end else if ((state_reg == DRAIN) && (cmd_reg.mode == MODE_OS)) begin
            idx_reg <= K_W'(N - 1) - K_W'(cnt_reg);
         end else if (ws_pipe_reg[2*N]) begin
            idx_reg <= idx_reg + K_W'(1);
         end
      end
   end

   assign res_valid = ws_pipe_reg[2*N] | os_res_reg;
   assign res_idx   = res_valid ? idx_reg : '0;

`ifdef SYSTOLIC_SEQ_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
      end else if (busy && (perf_cycles != '1)) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl (N=4, K_W=8, ADDR_W=10); checks SYSTOLIC_SEQ_PERF_EN when defined.
module tb_systolic_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_mode;
   logic [7:0] cmd_k;
   logic [9:0] cmd_a_base;
   logic [9:0] cmd_b_base;
   logic       a_rd_en;
   logic [9:0] a_rd_addr;
   logic       b_rd_en;
   logic [9:0] b_rd_addr;
   logic       arr_mode;
   logic       arr_state;
   logic       sum_zero;
   logic       res_valid;
   logic [7:0] res_idx;
   logic       busy;
   logic       done;
`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [31:0] perf_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   int a_cyc[$];
   int a_adr[$];
   int b_cyc[$];
   int b_adr[$];
   int res_cyc[$];
   int res_id[$];
   int done_cyc[$];
   int acc_cyc[$];
   int busy_n;
   logic st_log [64];
   logic sz_log [64];
   logic md_log [64];

   systolic_seq_ctrl #(
      .N      (4),
      .K_W    (8),
      .ADDR_W (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_k      (cmd_k),
      .cmd_a_base (cmd_a_base),
      .cmd_b_base (cmd_b_base),
      .a_rd_en    (a_rd_en),
      .a_rd_addr  (a_rd_addr),
      .b_rd_en    (b_rd_en),
      .b_rd_addr  (b_rd_addr),
      .arr_mode   (arr_mode),
      .arr_state  (arr_state),
      .sum_zero   (sum_zero),
      .res_valid  (res_valid),
      .res_idx    (res_idx),
      .busy       (busy),
      .done       (done)
`ifdef SYSTOLIC_SEQ_PERF_EN
      ,
      .perf_cycles(perf_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offers one command, then logs ncyc cycles; cycle 1 is the first cycle after the accept edge.
   task automatic run_cmd(input logic mode, input int k, input int ab, input int bb,
                          input bit hold, input int ncyc);
      int w;
      a_cyc.delete(); a_adr.delete(); b_cyc.delete(); b_adr.delete();
      res_cyc.delete(); res_id.delete(); done_cyc.delete(); acc_cyc.delete();
      busy_n = 0;
      for (int i = 0; i < 64; i++) begin
         st_log[i] = 1'b0; sz_log[i] = 1'b0; md_log[i] = 1'b0;
      end
      cmd_mode   = mode;
      cmd_k      = k[7:0];
      cmd_a_base = ab[9:0];
      cmd_b_base = bb[9:0];
      cmd_valid  = 1'b1;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_wait: cmd_ready=%b, required 1", cmd_ready);
      end
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         if (a_rd_en === 1'b1) begin a_cyc.push_back(c); a_adr.push_back(int'(a_rd_addr)); end
         if (b_rd_en === 1'b1) begin b_cyc.push_back(c); b_adr.push_back(int'(b_rd_addr)); end
         if (res_valid === 1'b1) begin res_cyc.push_back(c); res_id.push_back(int'(res_idx)); end
         if (done === 1'b1) done_cyc.push_back(c);
         if (busy === 1'b1) busy_n++;
         if (cmd_valid && cmd_ready === 1'b1) acc_cyc.push_back(c);
         if (c < 64) begin
            st_log[c] = arr_state; sz_log[c] = sum_zero; md_log[c] = arr_mode;
         end
         if (c < ncyc) begin @(posedge clk); #1; end
      end
      $display("cmd mode=%0d k=%0d a_base=0x%03h b_base=0x%03h: a_rd=%0d b_rd=%0d res=%0d done=%0d busy=%0d",
               mode, k, ab, bb, a_cyc.size(), b_cyc.size(), res_cyc.size(), done_cyc.size(), busy_n);
   endtask

   task automatic test_reset();
      cmd_valid = 0; cmd_mode = 0; cmd_k = 0; cmd_a_base = 0; cmd_b_base = 0;
      rst_n = 1'b0;
      #3;
      n_checks++;
      if (cmd_ready !== 1'b1 || {a_rd_en, b_rd_en, arr_mode, arr_state, sum_zero, res_valid, busy, done} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b others=%b, required ready=1 others=00000000",
                  cmd_ready, {a_rd_en, b_rd_en, arr_mode, arr_state, sum_zero, res_valid, busy, done});
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if (cmd_ready !== 1'b1 || {a_rd_en, b_rd_en, arr_mode, arr_state, sum_zero, res_valid, busy, done} !== 8'h00
             || a_rd_addr !== 10'h000 || b_rd_addr !== 10'h000 || res_idx !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_outputs cycle %0d: ready=%b flags=%b a_addr=%h b_addr=%h idx=%h, required 1/0/0/0/0",
                     c, cmd_ready, {a_rd_en, b_rd_en, arr_mode, arr_state, sum_zero, res_valid, busy, done},
                     a_rd_addr, b_rd_addr, res_idx);
         end
      end
`ifdef SYSTOLIC_SEQ_PERF_EN
      n_checks++;
      if (perf_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_idle: perf_cycles=%0d, required 0", perf_cycles);
      end
`endif
      $display("reset and idle checked");
   endtask

   task automatic test_ws();
      run_cmd(1'b0, 6, 'h020, 'h010, 1'b0, 22);
      n_checks++;
      if (b_cyc.size() != 4) begin n_fail++; $display("FAIL ws_b_count: got %0d, required 4", b_cyc.size()); end
      for (int i = 0; i < b_cyc.size() && i < 4; i++) begin
         n_checks++;
         if (b_cyc[i] !== 1 + i || b_adr[i] !== 'h13 - i) begin
            n_fail++;
            $display("FAIL ws_b_read %0d: cycle %0d addr 0x%03h, required cycle %0d addr 0x%03h", i, b_cyc[i], b_adr[i], 1 + i, 'h13 - i);
         end
      end
      n_checks++;
      if (a_cyc.size() != 6) begin n_fail++; $display("FAIL ws_a_count: got %0d, required 6", a_cyc.size()); end
      for (int i = 0; i < a_cyc.size() && i < 6; i++) begin
         n_checks++;
         if (a_cyc[i] !== 5 + i || a_adr[i] !== 'h20 + i) begin
            n_fail++;
            $display("FAIL ws_a_read %0d: cycle %0d addr 0x%03h, required cycle %0d addr 0x%03h", i, a_cyc[i], a_adr[i], 5 + i, 'h20 + i);
         end
      end
      n_checks++;
      if (res_cyc.size() != 6) begin n_fail++; $display("FAIL ws_res_count: got %0d, required 6", res_cyc.size()); end
      for (int i = 0; i < res_cyc.size() && i < 6; i++) begin
         n_checks++;
         if (res_cyc[i] !== 14 + i || res_id[i] !== i) begin
            n_fail++;
            $display("FAIL ws_res %0d: cycle %0d idx %0d, required cycle %0d idx %0d", i, res_cyc[i], res_id[i], 14 + i, i);
         end
      end
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] !== 18) begin
         n_fail++;
         $display("FAIL ws_done: count %0d first %0d, required count 1 at cycle 18", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      n_checks++;
      if (busy_n !== 17) begin n_fail++; $display("FAIL ws_busy: %0d cycles, required 17", busy_n); end
      n_checks++;
      if ({st_log[5], st_log[6], st_log[18], st_log[19], sz_log[5], sz_log[6], md_log[6]} !== 7'b0110010) begin
         n_fail++;
         $display("FAIL ws_ctrl: st5/6/18/19 sz5/6 md6 = %b, required 0110010",
                  {st_log[5], st_log[6], st_log[18], st_log[19], sz_log[5], sz_log[6], md_log[6]});
      end
   endtask

   task automatic test_os();
      run_cmd(1'b1, 5, 'h040, 'h080, 1'b0, 20);
      n_checks++;
      if (a_cyc.size() != 5 || b_cyc.size() != 5) begin
         n_fail++;
         $display("FAIL os_read_count: a=%0d b=%0d, required 5 and 5", a_cyc.size(), b_cyc.size());
      end
      for (int i = 0; i < a_cyc.size() && i < b_cyc.size() && i < 5; i++) begin
         n_checks++;
         if (a_cyc[i] !== 2 + i || b_cyc[i] !== 2 + i || a_adr[i] !== 'h40 + i || b_adr[i] !== 'h80 + i) begin
            n_fail++;
            $display("FAIL os_read %0d: a cyc %0d addr 0x%03h b cyc %0d addr 0x%03h, required cyc %0d addrs 0x%03h 0x%03h",
                     i, a_cyc[i], a_adr[i], b_cyc[i], b_adr[i], 2 + i, 'h40 + i, 'h80 + i);
         end
      end
      n_checks++;
      if (res_cyc.size() != 4) begin n_fail++; $display("FAIL os_res_count: got %0d, required 4", res_cyc.size()); end
      for (int i = 0; i < res_cyc.size() && i < 4; i++) begin
         n_checks++;
         if (res_cyc[i] !== 14 + i || res_id[i] !== 3 - i) begin
            n_fail++;
            $display("FAIL os_res %0d: cycle %0d idx %0d, required cycle %0d idx %0d", i, res_cyc[i], res_id[i], 14 + i, 3 - i);
         end
      end
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] !== 17) begin
         n_fail++;
         $display("FAIL os_done: count %0d first %0d, required count 1 at cycle 17", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      n_checks++;
      if (busy_n !== 16) begin n_fail++; $display("FAIL os_busy: %0d cycles, required 16", busy_n); end
      // Compute spans 11 cycles, visible on arr_state one cycle late: high on cycles 3..13.
      n_checks++;
      if ({st_log[2], st_log[3], st_log[13], st_log[14], sz_log[2], sz_log[3], sz_log[14], md_log[5]} !== 8'b01101011) begin
         n_fail++;
         $display("FAIL os_ctrl: st2/3/13/14 sz2/3/14 md5 = %b, required 01101011",
                  {st_log[2], st_log[3], st_log[13], st_log[14], sz_log[2], sz_log[3], sz_log[14], md_log[5]});
      end
   endtask

   task automatic test_k0();
      run_cmd(1'b0, 0, 'h020, 'h010, 1'b0, 5);
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] !== 1) begin
         n_fail++;
         $display("FAIL k0_done: count %0d first %0d, required count 1 at cycle 1", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      n_checks++;
      if (a_cyc.size() != 0 || b_cyc.size() != 0 || res_cyc.size() != 0 || busy_n != 0) begin
         n_fail++;
         $display("FAIL k0_quiet: a=%0d b=%0d res=%0d busy=%0d, required all 0", a_cyc.size(), b_cyc.size(), res_cyc.size(), busy_n);
      end
   endtask

   task automatic test_wrap();
      int exp_b[4];
      int exp_a[2];
      exp_b = '{'h001, 'h000, 'h3FF, 'h3FE};
      exp_a = '{'h3FF, 'h000};
      run_cmd(1'b0, 2, 'h3FF, 'h3FE, 1'b0, 16);
      n_checks++;
      if (b_cyc.size() != 4 || a_cyc.size() != 2) begin
         n_fail++;
         $display("FAIL wrap_count: b=%0d a=%0d, required 4 and 2", b_cyc.size(), a_cyc.size());
      end
      for (int i = 0; i < b_cyc.size() && i < 4; i++) begin
         n_checks++;
         if (b_adr[i] !== exp_b[i]) begin
            n_fail++;
            $display("FAIL wrap_b %0d: addr 0x%03h, required 0x%03h", i, b_adr[i], exp_b[i]);
         end
      end
      for (int i = 0; i < a_cyc.size() && i < 2; i++) begin
         n_checks++;
         if (a_adr[i] !== exp_a[i]) begin
            n_fail++;
            $display("FAIL wrap_a %0d: addr 0x%03h, required 0x%03h", i, a_adr[i], exp_a[i]);
         end
      end
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] !== 14 || res_cyc.size() != 2) begin
         n_fail++;
         $display("FAIL wrap_done: done count %0d res count %0d, required done at 14 and 2 results", done_cyc.size(), res_cyc.size());
      end
   endtask

   task automatic test_back_to_back();
      run_cmd(1'b0, 2, 'h000, 'h100, 1'b1, 30);
      n_checks++;
      if (done_cyc.size() != 2 || done_cyc[0] !== 14 || done_cyc[1] !== 29) begin
         n_fail++;
         $display("FAIL b2b_done: count %0d, required 2 at cycles 14 and 29", done_cyc.size());
      end
      n_checks++;
      if (acc_cyc.size() != 2 || acc_cyc[0] !== 15 || acc_cyc[1] !== 30) begin
         n_fail++;
         $display("FAIL b2b_accept: count %0d first %0d, required 2 at cycles 15 and 30",
                  acc_cyc.size(), acc_cyc.size() > 0 ? acc_cyc[0] : -1);
      end
      n_checks++;
      if (b_cyc.size() != 8 || b_cyc[4] !== 16) begin
         n_fail++;
         $display("FAIL b2b_second_run: b reads %0d, required 8 with second run starting at cycle 16", b_cyc.size());
      end
      cmd_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int dn;
      run_cmd(1'b0, 6, 'h020, 'h010, 1'b0, 6);
      n_checks++;
      if (a_rd_en !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_compute: a_rd_en=%b busy=%b, required 1 1", a_rd_en, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1 || {a_rd_en, b_rd_en, arr_mode, arr_state, sum_zero, res_valid, busy, done} !== 8'h00
          || a_rd_addr !== 10'h000 || res_idx !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: ready=%b flags=%b a_addr=%h, required 1/00000000/000",
                  cmd_ready, {a_rd_en, b_rd_en, arr_mode, arr_state, sum_zero, res_valid, busy, done}, a_rd_addr);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      dn = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) dn++;
      end
      n_checks++;
      if (dn != 0) begin n_fail++; $display("FAIL abort_quiet: %0d cycles with done/busy, required 0", dn); end
      run_cmd(1'b1, 3, 'h100, 'h200, 1'b0, 17);
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] !== 15) begin
         n_fail++;
         $display("FAIL rerun_done: count %0d first %0d, required count 1 at cycle 15", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      n_checks++;
      if (res_cyc.size() != 4 || res_cyc[0] !== 12 || res_id[0] !== 3 || res_id[3] !== 0 || a_cyc.size() != 3) begin
         n_fail++;
         $display("FAIL rerun_res: res %0d a_rd %0d, required 4 results from cycle 12 idx 3..0 and 3 reads",
                  res_cyc.size(), a_cyc.size());
      end
`ifdef SYSTOLIC_SEQ_PERF_EN
      n_checks++;
      if (perf_cycles !== 32'd14) begin
         n_fail++;
         $display("FAIL perf_cycles: %0d, required 14", perf_cycles);
      end
`else
      n_checks++;
      if (busy_n !== 14) begin
         n_fail++;
         $display("FAIL rerun_busy: %0d cycles, required 14", busy_n);
      end
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      test_reset();
      test_ws();
      test_os();
      test_k0();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
